i2v_int: RTL and testbench

I2V_INT -- requirements
Module: i2v_int

---
 rtl/i2v_pkg.sv | 24 ++
 rtl/i2v_int.sv | 99 +++++++++
 tb/tb_i2v_int.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2v_pkg.sv
// Shared types and real-valued helpers for the current-to-voltage integrator.
package i2v_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INTEG,
    HOLD
  } state_e;

  // Limit x to the closed range [lo, hi].
  function automatic real clamp(input real x, input real lo, input real hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // A double is non-finite (NaN or +/-inf) exactly when its exponent field is all ones.
  function automatic logic is_finite(input real x);
    logic [63:0] b;
    b = $realtobits(x);
    return (b[62:52] != '1);
  endfunction

endpackage

// File: rtl/i2v_int.sv
// Integrating current-to-voltage converter: START begins an N_INT-cycle
// integration of IIN onto a virtual capacitor C; the clamped result is
// presented on VOUT with a VALID/ACK handshake.
module i2v_int
  import i2v_pkg::*;
#(
  parameter real C     = 1.0e-9,
  parameter real TCLK  = 1.0e-6,
  parameter int  N_INT = 16,
  parameter real I_MIN = -10.0e-3,
  parameter real I_MAX = 10.0e-3,
  parameter real V_MIN = -5.0,
  parameter real V_MAX = 5.0
) (
  input  logic CLK,
  input  logic RST_N,
  input  real  IIN,
  input  logic START,
  input  logic ACK,
  output real  VOUT,
  output logic VALID,
  output logic BUSY,
  output logic SAT
);

  localparam int  CW    = $clog2(N_INT + 1);
  localparam real KSTEP = TCLK / C;

  state_e        state_q, state_d;
  real           vacc_q, vacc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  real           vout_q, vout_d;
  logic          sat_q, sat_d;

  real  i_in, i_clamped, v_sum;
  logic i_hit, v_hit;

  // Next-state, accumulator, counter and result computation.
  always_comb begin
    state_d   = state_q;
    vacc_d    = vacc_q;
    cnt_d     = cnt_q;
    vout_d    = vout_q;
    sat_d     = sat_q;

    i_in      = is_finite(IIN) ? IIN : 0.0;
    i_clamped = clamp(i_in, I_MIN, I_MAX);
    i_hit     = (i_in < I_MIN) || (i_in > I_MAX);
    v_sum     = vacc_q + i_clamped * KSTEP;
    v_hit     = (v_sum < V_MIN) || (v_sum > V_MAX);

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = INTEG;
          vacc_d  = 0.0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      INTEG: begin
        vacc_d = clamp(v_sum, V_MIN, V_MAX);
        cnt_d  = cnt_q + CW'(1);
        if (i_hit || v_hit) sat_d = 1'b1;
        if (cnt_q == CW'(N_INT - 1)) begin
          vout_d  = vacc_d;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous clear of every piece of state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      vacc_q  <= 0.0;
      cnt_q   <= '0;
      vout_q  <= 0.0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vacc_q  <= vacc_d;
      cnt_q   <= cnt_d;
      vout_q  <= vout_d;
      sat_q   <= sat_d;
    end
  end

  assign VOUT  = vout_q;
  assign VALID = (state_q == HOLD);
  assign BUSY  = (state_q != IDLE);
  assign SAT   = sat_q;

endmodule

// File: tb/tb_i2v_int.sv
// Scoreboard bench for i2v_int: the driver pushes expected results, a
// monitor pops and compares them when VALID rises.
module tb_i2v_int;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic ack = 1'b0;
  real  iin = 0.0;
  real  vout;
  logic valid, busy, sat;

  i2v_int #(.C(1.0e-9), .TCLK(1.0e-6), .N_INT(N)) dut (
    .CLK(clk), .RST_N(rst_n), .IIN(iin), .START(start), .ACK(ack),
    .VOUT(vout), .VALID(valid), .BUSY(busy), .SAT(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    real         v;
    logic        s;
    int unsigned c0;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic        valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real exp);
    real d;
    total++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (!(d <= 1.0e-9)) begin
      bad++;
      $display("FAIL %s: got %g want %g at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: ideal capacitor charged by the clamped sample sequence.
  function automatic void model(input real s[N], output real v, output logic st);
    real acc;
    acc = 0.0;
    st  = 1'b0;
    for (int i = 0; i < N; i++) begin
      real x;
      x = s[i];
      if ((x != x) || (x > 1.0e300) || (x < -1.0e300)) x = 0.0;
      if (x > 10.0e-3)       begin x = 10.0e-3;  st = 1'b1; end
      else if (x < -10.0e-3) begin x = -10.0e-3; st = 1'b1; end
      acc = acc + x * 1.0e-6 / 1.0e-9;
      if (acc > 5.0)       begin acc = 5.0;  st = 1'b1; end
      else if (acc < -5.0) begin acc = -5.0; st = 1'b1; end
    end
    v = acc;
  endfunction

  // Monitor: every VALID rise must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid && !valid_prev) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got VALID=1 want no result at t=%0t", $time);
      end else begin
        e = sbq.pop_front();
        chk_real("vout", vout, e.v);
        chk_bit("sat", sat, e.s);
        chk_int("latency", int'(cyc - e.c0), N);
      end
    end
    valid_prev = rst_n ? valid : 1'b0;
  end

  // One conversion. fixed selects literal expectations instead of the model;
  // abort_at >= 0 pulses reset after that many INTEG edges.
  task automatic conv(input real s[N], input bit fixed, input real fv, input logic fs,
                      input bit mid_start, input bit hold_start, input bit ack_start,
                      input int abort_at);
    real  ev;
    logic es;
    exp_t e;
    if (fixed) begin ev = fv; es = fs; end
    else model(s, ev, es);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.v = ev; e.s = es; e.c0 = cyc;
    sbq.push_back(e);
    for (int k = 0; k < N; k++) begin
      if (abort_at == k) begin
        rst_n = 1'b0;
        #1;
        chk_real("abort_vout", vout, 0.0);
        chk_bit("abort_valid", valid, 1'b0);
        chk_bit("abort_busy", busy, 1'b0);
        chk_bit("abort_sat", sat, 1'b0);
        void'(sbq.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        iin = 0.0;
        return;
      end
      iin   = s[k];
      start = mid_start && (k == 5);
      ack   = mid_start && (k == 3);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    ack   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_bit("hold_valid", valid, 1'b1);
      chk_real("hold_vout", vout, ev);
    end
    if (hold_start) begin
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk_bit("hold_start_busy", busy, 1'b1);
      chk_bit("hold_start_valid", valid, 1'b1);
    end
    @(negedge clk);
    ack   = 1'b1;
    start = ack_start;
    @(posedge clk);
    #1;
    ack   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_bit("ack_valid", valid, 1'b0);
    chk_bit("ack_busy", busy, 1'b0);
    chk_real("idle_vout", vout, ev);
    @(negedge clk);
    chk_bit("idle_stays", busy, 1'b0);
  endtask

  initial begin
    real s[N];
    #3 rst_n = 1'b0;
    #2;
    chk_real("rst_vout", vout, 0.0);
    chk_bit("rst_valid", valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_sat", sat, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (s[k]) s[k] = 1.0e-6;
    conv(s, 1'b1, 16.0e-3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    foreach (s[k]) s[k] = -2.0e-6;
    conv(s, 1'b1, -32.0e-3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    foreach (s[k]) s[k] = 1.0e-3;
    conv(s, 1'b1, 5.0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    foreach (s[k]) s[k] = 20.0e-3;
    conv(s, 1'b1, 5.0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    foreach (s[k]) s[k] = 1.0e-6;
    conv(s, 1'b1, 16.0e-3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    foreach (s[k]) s[k] = 20.0e-3;
    conv(s, 1'b1, 5.0, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    foreach (s[k]) s[k] = 1.0e-6;
    conv(s, 1'b1, 16.0e-3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    foreach (s[k]) s[k] = 1.0e-6;
    conv(s, 1'b1, 16.0e-3, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    foreach (s[k]) s[k] = 1.0e-6;
    s[3]  = $bitstoreal(64'h7FF8000000000000);
    s[7]  = $bitstoreal(64'h7FF0000000000000);
    s[10] = $bitstoreal(64'hFFF0000000000000);
    conv(s, 1'b1, 13.0e-3, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    for (int n = 0; n < 12; n++) begin
      foreach (s[k]) begin
        case ($urandom_range(0, 3))
          0:       s[k] = (real'($urandom_range(0, 2000)) - 1000.0) * 1.0e-9;
          1:       s[k] = (real'($urandom_range(0, 40000)) - 20000.0) * 1.0e-6;
          default: s[k] = (real'($urandom_range(0, 2000)) - 1000.0) * 1.0e-6;
        endcase
      end
      conv(s, 1'b0, 0.0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending_results: got %0d outstanding want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
